// File: rtl/if_fetch_queue_if.sv
// Fetch-queue handshake bundle: IF-side push channel and ID-side head channel.
interface if_fetch_queue_if #(
  parameter int unsigned TRAP_LEN = 3,
  parameter int unsigned HISLEN   = 8
);
  // IF -> queue
  logic                if_valid_i;
  logic                if_ready_o;
  logic [31:0]         if_pc_i;
  logic [31:0]         if_inst_i;
  logic                if_is_c_i;
  logic [TRAP_LEN-1:0] if_trap_i;
  logic                if_pdt_res_i;
  logic [31:0]         if_pdt_pc_tag_i;
  logic [HISLEN-1:0]   if_history_i;

  // queue -> ID
  logic                id_valid_o;
  logic                id_ready_i;
  logic [31:0]         id_pc_o;
  logic [31:0]         id_inst_o;
  logic                id_is_c_o;
  logic [TRAP_LEN-1:0] id_trap_o;
  logic                id_pdt_res_o;
  logic [31:0]         id_pdt_pc_tag_o;
  logic [HISLEN-1:0]   id_history_o;

  // Environment side: drives fetches and the ID ready.
  modport master (
    output if_valid_i, if_pc_i, if_inst_i, if_is_c_i, if_trap_i,
           if_pdt_res_i, if_pdt_pc_tag_i, if_history_i, id_ready_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_inst_o, id_is_c_o,
           id_trap_o, id_pdt_res_o, id_pdt_pc_tag_o, id_history_o
  );

  // Queue side.
  modport slave (
    input  if_valid_i, if_pc_i, if_inst_i, if_is_c_i, if_trap_i,
           if_pdt_res_i, if_pdt_pc_tag_i, if_history_i, id_ready_i,
    output if_ready_o, id_valid_o, id_pc_o, id_inst_o, id_is_c_o,
           id_trap_o, id_pdt_res_o, id_pdt_pc_tag_o, id_history_o
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: circular buffer between the fetch stage and ID,
// with flush-on-redirect and a hold that blocks fetches after a trapping entry.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TRAP_LEN = 3,
  parameter int unsigned HISLEN   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  if_fetch_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = CW - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic                is_c;
    logic [TRAP_LEN-1:0] trap;
    logic                pdt_res;
    logic [31:0]         pdt_pc_tag;
    logic [HISLEN-1:0]   history;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [CW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_rd_ptr;
  logic            r_trap_hold;

  logic            w_empty;
  logic            w_full;
  logic            w_if_ready;
  logic            w_id_valid;
  logic            w_push;
  logic            w_pop;
  entry_t          w_in;
  entry_t          w_head;

  // Occupancy flags from pointer compare; the MSB disambiguates full from empty.
  always_comb begin
    w_empty    = (r_wr_ptr == r_rd_ptr);
    w_full     = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) &&
                 (r_wr_ptr[CW-1] != r_rd_ptr[CW-1]);
    w_if_ready = !w_full && !r_trap_hold && !flush_i;
    w_id_valid = !w_empty && !flush_i;
    w_push     = bus.if_valid_i && w_if_ready;
    w_pop      = w_id_valid && bus.id_ready_i;
  end

  // Pack the incoming fetch into a storage entry.
  always_comb begin
    w_in.pc         = bus.if_pc_i;
    w_in.inst       = bus.if_inst_i;
    w_in.is_c       = bus.if_is_c_i;
    w_in.trap       = bus.if_trap_i;
    w_in.pdt_res    = bus.if_pdt_res_i;
    w_in.pdt_pc_tag = bus.if_pdt_pc_tag_i;
    w_in.history    = bus.if_history_i;
  end

  // Pointer and trap-hold state; flush returns everything to the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_trap_hold <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_trap_hold <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + CW'(1);
        if (|bus.if_trap_i) r_trap_hold <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  // Entry storage; not reset, contents only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[IW-1:0]] <= w_in;
  end

  // Head presentation: stored entry when valid, NOP bubble otherwise.
  always_comb begin
    w_head      = '0;
    w_head.inst = NOP;
    if (w_id_valid) w_head = r_mem[r_rd_ptr[IW-1:0]];
  end

  // Drive the interface outputs.
  always_comb begin
    bus.if_ready_o      = w_if_ready;
    bus.id_valid_o      = w_id_valid;
    bus.id_pc_o         = w_head.pc;
    bus.id_inst_o       = w_head.inst;
    bus.id_is_c_o       = w_head.is_c;
    bus.id_trap_o       = w_head.trap;
    bus.id_pdt_res_o    = w_head.pdt_res;
    bus.id_pdt_pc_tag_o = w_head.pdt_pc_tag;
    bus.id_history_o    = w_head.history;
    count_o             = r_wr_ptr - r_rd_ptr;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue between the `ifu` fetch stage and the ID stage. It holds up to DEPTH fetched instructions together with their PC, trap bits, compressed flag and branch-prediction tags. This decouples instruction-cache and MMU latency from decode stalls. It also absorbs redirects by discarding everything on `flush_i`, and stops accepting fetches after a faulting instruction until that flush arrives.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- CW, $clog2(DEPTH)+1, pointer and count width (derived; do not override)

- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush_i  input  1  redirect/exception flush, synchronous
- if_valid_i  input  1  ifu presents an instruction
- if_ready_o  output  1  queue accepts this cycle
- if_pc_i  input  32  instruction PC
- if_inst_i  input  32  instruction, already expanded to 32 bits
- if_is_c_i  input  1  original instruction was RVC
- if_trap_i  input  `TRAP_LEN  fetch trap bits (misaligned, access fault, page fault)
- if_pdt_res_i  input  1  predicted taken
- if_pdt_pc_tag_i  input  32  predicted target
- if_history_i  input  `HISLEN  predictor history snapshot
- id_valid_o  output  1  head entry valid
- id_ready_i  input  1  ID consumes head this cycle
- id_pc_o, id_inst_o, id_is_c_o, id_trap_o, id_pdt_res_o, id_pdt_pc_tag_o, id_history_o  output  (same widths as inputs)  head entry fields
- count_o  output  CW  occupied entries, 0..DEPTH

## Operation
- Storage is a circular register array. wr_ptr and rd_ptr are CW bits wide; the low CW-1 bits index the array and the MSB is the wrap bit.
  - empty: wr_ptr == rd_ptr
  - full: index bits equal and wrap bits differ
- push = if_valid_i & if_ready_o
  - writes entry[wr_ptr]
  - wr_ptr increments with natural wrap at 2^CW
- pop = id_valid_o & id_ready_i; rd_ptr increments.
- if_ready_o = !full & !trap_hold & !flush_i
- id_valid_o = !empty & !flush_i
- Head outputs:
  - when id_valid_o=1, all id_* fields come from entry[rd_ptr] combinationally.
  - when id_valid_o=0: id_inst_o = 32'h00000013 (NOP) and all other id_* fields are 0.
- count_o = wr_ptr − rd_ptr, mod 2^CW.
- trap_hold register:
  - set on a push whose if_trap_i is nonzero.
  - while set, no further push is accepted.
  - cleared only by flush_i or reset; pops do not clear it.
- flush_i:
  - on the next edge, wr_ptr = rd_ptr = 0 and trap_hold = 0.
  - any push or pop in the flush cycle is suppressed.
- Reset (rst_n low, asynchronous):
  - pointers 0, trap_hold 0.
  - therefore id_valid_o=0, id_inst_o=NOP, count_o=0, if_ready_o=1 once rst_n is high (when flush_i=0).
  - entry array is not reset.
- Reset asserted mid-operation discards all entries immediately, with no completion of an in-flight push.

## Timing
- Latency: an instruction pushed at edge N appears on id_valid_o after edge N. There is no same-cycle bypass when empty.
- Throughput: one push and one pop per cycle.
- Simultaneous push and pop:
  - non-full: both occur, count unchanged.
  - full: if_ready_o=0, so only the pop occurs. A slot is visible to if_ready_o the cycle after the pop; there is no same-cycle refill when full.
  - empty: the push occurs and the pop is impossible (id_valid_o=0).
- if_ready_o depends only on state and flush_i, not on id_ready_i. There is no combinational path from ID to IF.
- Handshake rules:
  - ifu must hold if_* stable while if_valid_i=1 and if_ready_o=0.
  - ID may drop id_ready_i at any time.
- Pointer wrap: after 2^CW pushes, full/empty detection must still be correct, including at DEPTH=2.

## Test plan
- Reset, then push PCs 0x80000000/04/08 with id_ready_i=0 → count_o=3. Then raise id_ready_i → id_pc_o shows 0x80000000, 04, 08 on consecutive cycles, then id_valid_o=0 with id_inst_o=0x00000013.
- Fill to DEPTH=4 and hold if_valid_i=1 → if_ready_o=0 and count_o=4. Pop once → if_ready_o=1 the next cycle, and the fifth PC lands at the tail in order.
- Continuous push+pop for 20 cycles with incrementing PCs → count_o constant, no loss or duplication across pointer wrap. Repeat with DEPTH=2.
- Push 0x80000010 with the page-fault trap bit set, then keep if_valid_i=1 → that entry is popped with id_trap_o bit set and no later PCs are accepted. Assert flush_i → if_ready_o=1 the following cycle.
- With 3 entries queued, assert flush_i together with if_valid_i and id_ready_i → id_valid_o=0 that cycle, count_o=0 next, and the concurrent push is not stored.
- Drop rst_n asynchronously mid-cycle with 2 entries queued → id_valid_o falls without waiting for a clock edge, count_o=0; after release, if_ready_o=1.
